// File: rtl/shift_pkg.sv
// Shared definitions for the shift_seq block.
//   DEF_WIDTH          default data width
//   OP_SLL/OP_SRL/OP_SRA  operation encodings (2'b11 is reserved and treated as SLL)
//   state_e            sequencer states
package shift_pkg;

  localparam int unsigned DEF_WIDTH = 16;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    FIN   = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// One-bit shift datapath.
// Build option: SHIFT_SEQ_SRA_EN -- when defined, OP_SRA fills with the sign
// bit; otherwise OP_SRA behaves exactly as OP_SRL.
// Ports:
//   value_i  WIDTH  value to shift
//   op_i     2      operation (OP_SLL / OP_SRL / OP_SRA, 2'b11 acts as SLL)
//   value_o  WIDTH  value shifted by one bit
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic [1:0]       op_i,
  output logic [WIDTH-1:0] value_o
);

  always_comb begin
    case (op_i)
      OP_SRL: value_o = {1'b0, value_i[WIDTH-1:1]};
`ifdef SHIFT_SEQ_SRA_EN
      OP_SRA: value_o = {value_i[WIDTH-1], value_i[WIDTH-1:1]};
`else
      OP_SRA: value_o = {1'b0, value_i[WIDTH-1:1]};
`endif
      default: value_o = {value_i[WIDTH-2:0], 1'b0};
    endcase
  end

endmodule

// File: rtl/shift_seq.sv
// Sequential shifter: shifts A by B[log2(WIDTH)-1:0] bit positions, one bit
// per clock, and presents the result on O with a one-cycle DONE pulse.
// Build option: SHIFT_SEQ_SRA_EN enables arithmetic right shift for OP=10.
// Ports:
//   CLK    in   rising-edge clock
//   RST_N  in   asynchronous active-low reset
//   START  in   request; A/B/OP sampled when accepted in IDLE
//   OP     in   2-bit operation (00 SLL, 01 SRL, 10 SRA, 11 as SLL)
//   A      in   value to shift
//   B      in   shift amount (only the low log2(WIDTH) bits are used)
//   READY  out  high in IDLE
//   BUSY   out  high in SHIFT
//   DONE   out  high for the single FIN cycle
//   O      out  result register, updated only on entry to FIN
module shift_seq
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [1:0]       OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             READY,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] O
);

  localparam int unsigned AW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] step_val;
  logic             accept;
  logic             unused_b;

  assign unused_b = ^B[WIDTH-1:AW];
  assign accept   = (state_q == IDLE) && START;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .value_i (work_q),
    .op_i    (op_q),
    .value_o (step_val)
  );

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; SHIFT leaves on the edge that takes the counter to 0
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (START) state_d = (B[AW-1:0] == '0) ? FIN : SHIFT;
      SHIFT:   if (cnt_q == AW'(1)) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    READY = (state_q == IDLE);
    BUSY  = (state_q == SHIFT);
    DONE  = (state_q == FIN);
  end

  // Datapath next values. O captures the value work is about to hold, so the
  // result is already on O during the FIN cycle.
  always_comb begin
    work_d = work_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    o_d    = o_q;
    if (accept) begin
      work_d = A;
      cnt_d  = B[AW-1:0];
      op_d   = OP;
    end else if (state_q == SHIFT) begin
      work_d = step_val;
      cnt_d  = cnt_q - AW'(1);
    end
    if (state_d == FIN) o_d = work_d;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      work_q <= '0;
      cnt_q  <= '0;
      op_q   <= '0;
      o_q    <= '0;
    end else begin
      work_q <= work_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      o_q    <= o_d;
    end
  end

  assign O = o_q;

endmodule

// File: tb/tb_shift_seq.sv
// Directed self-checking bench for shift_seq. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_shift_seq;

  logic        CLK;
  logic        RST_N;
  logic        START;
  logic [1:0]  OP;
  logic [15:0] A;
  logic [15:0] B;
  logic        READY;
  logic        BUSY;
  logic        DONE;
  logic [15:0] O;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  shift_seq #(.WIDTH(16)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .START (START),
    .OP    (OP),
    .A     (A),
    .B     (B),
    .READY (READY),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .O     (O)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation from accept to the IDLE cycle after FIN. exp_lat is the
  // cycle (counted from the accept edge) in which DONE must be high.
  // poke drives a junk START pulse during the first SHIFT cycle.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp_o,
                        input int unsigned exp_lat, input bit poke);
    int unsigned lat;
    bit          busy_seen;
    bit          got;
    logic [15:0] o_prev;
    check({tag, "/ready"}, READY, 1);
    o_prev = O;
    START = 1'b1; OP = op; A = a; B = b;
    @(negedge CLK);
    START = 1'b0; OP = 2'b11; A = 16'hA5C3; B = 16'h0007;
    lat = 0; busy_seen = 0; got = 0;
    for (int i = 1; i <= 40 && !got; i++) begin
      if (DONE) begin
        got = 1;
        lat = i;
      end else begin
        if (BUSY) busy_seen = 1;
        check({tag, "/hold"}, O, o_prev);
        if (poke && i == 1) begin
          START = 1'b1; OP = 2'b00; A = 16'hFFFF; B = 16'h0000;
        end
        if (poke && i == 2) START = 1'b0;
        @(negedge CLK);
      end
    end
    check({tag, "/lat"}, lat, exp_lat);
    check({tag, "/o"}, O, exp_o);
    check({tag, "/busy"}, busy_seen, (exp_lat > 1) ? 1 : 0);
    @(negedge CLK);
    check({tag, "/ready_after"}, READY, 1);
    check({tag, "/done_after"}, DONE, 0);
    check({tag, "/o_after"}, O, exp_o);
  endtask

  initial begin
    int unsigned dones;
    int unsigned last_done;
    bit          prev_done;

    RST_N = 1'b0; START = 1'b0; OP = 2'b00; A = '0; B = '0;
    #12;
    check("rst/ready", READY, 1);
    check("rst/busy", BUSY, 0);
    check("rst/done", DONE, 0);
    check("rst/o", O, 16'h0000);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    run_op("sll15", 2'b00, 16'h0001, 16'h000F, 16'h8000, 16, 0);
    run_op("sll0",  2'b00, 16'h0001, 16'h0000, 16'h0001, 1, 0);
`ifdef SHIFT_SEQ_SRA_EN
    run_op("sra4",  2'b10, 16'h8000, 16'h0004, 16'hF800, 5, 0);
`else
    run_op("sra4",  2'b10, 16'h8000, 16'h0004, 16'h0800, 5, 0);
`endif
    run_op("srl_b11", 2'b01, 16'hF000, 16'h0011, 16'h7800, 2, 0);
    run_op("srl_poke", 2'b01, 16'h0F0F, 16'h0003, 16'h01E1, 4, 1);
    @(negedge CLK);
    check("poke/idle", READY, 1);
    check("poke/o", O, 16'h01E1);
    run_op("rsvd", 2'b11, 16'h00F0, 16'h0004, 16'h0F00, 5, 0);

    // Reset in the middle of a 10-bit shift
    START = 1'b1; OP = 2'b00; A = 16'h1234; B = 16'h000A;
    @(negedge CLK);
    START = 1'b0;
    repeat (3) @(negedge CLK);
    check("abort/busy_pre", BUSY, 1);
    RST_N = 1'b0;
    #1;
    check("abort/ready", READY, 1);
    check("abort/busy", BUSY, 0);
    check("abort/done", DONE, 0);
    check("abort/o", O, 16'h0000);
    @(negedge CLK);
    RST_N = 1'b1;
    dones = 0;
    repeat (15) begin
      @(negedge CLK);
      if (DONE) dones++;
    end
    check("abort/no_done", dones, 0);
    run_op("post_rst", 2'b00, 16'h0003, 16'h0001, 16'h0006, 2, 0);

    // START held: three back-to-back shifts by 2, one op every 4 cycles
    dones = 0; last_done = 0; prev_done = 0;
    START = 1'b1; OP = 2'b00; A = 16'h0003; B = 16'h0002;
    for (int i = 1; i <= 16; i++) begin
      @(negedge CLK);
      if (prev_done) begin
        check("b2b/ready", READY, 1);
        check("b2b/o", O, 16'h000C);
      end
      prev_done = DONE;
      if (DONE) begin
        dones++;
        last_done = i;
        if (dones == 3) START = 1'b0;
      end
    end
    check("b2b/count", dones, 3);
    check("b2b/last", last_done, 11);
    check("b2b/idle", READY, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
